// File: rtl/k16_panel_pkg.sv
// rtl/k16_panel_pkg.sv - shared types and constants for the front-panel serial bridge
package k16_panel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned FRAME_BITS = 8;
  localparam int unsigned SW_BITS    = 4;

  // Pin levels whenever no transfer phase is driving them
  localparam logic IDLE_SR_CLK    = 1'b0;
  localparam logic IDLE_SR_DATA   = 1'b0;
  localparam logic IDLE_SR_LATCH  = 1'b0;
  localparam logic IDLE_SR_LOAD_N = 1'b1;

  localparam logic [SW_BITS-1:0] SW_RESET = 4'hF;

endpackage

// File: rtl/k16_tick_div.sv
// rtl/k16_tick_div.sv - 8-bit half-period counter with terminal-count pulse
module k16_tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [7:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == 8'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!en || clr || tc) cnt_d = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/k16_panel_serial.sv
// rtl/k16_panel_serial.sv - front-panel bridge to a 74HC595/74HC165 shift-register chain
module k16_panel_serial
  import k16_panel_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_clk,
  input  logic [2:0]           io_addr,
  input  logic [3:0]           io_leds,
  output logic [SW_BITS-1:0]   io_switches,
  output logic                 sr_clk,
  output logic                 sr_data,
  output logic                 sr_latch,
  output logic                 sr_load_n,
  input  logic                 sr_din,
  output logic                 busy
);

  state_t                  state_q, state_d;
  logic                    io_clk_q;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [2:0]              bit_q, bit_d;
  logic                    phase_q, phase_d;
  logic [SW_BITS-1:0]      cap_q, cap_d;
  logic [SW_BITS-1:0]      sw_q, sw_d;
  logic                    tc;
  logic                    start;

  assign start       = io_clk && !io_clk_q;
  assign busy        = (state_q != ST_IDLE);
  assign io_switches = sw_q;

  k16_tick_div #(.DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (busy),
    .clr   (state_d != state_q),
    .tc    (tc)
  );

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    cap_d     = cap_q;
    sw_d      = sw_q;
    sr_clk    = IDLE_SR_CLK;
    sr_data   = IDLE_SR_DATA;
    sr_latch  = IDLE_SR_LATCH;
    sr_load_n = IDLE_SR_LOAD_N;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          frame_d = {io_leds, 1'b0, io_addr};
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_load_n = 1'b0;
        if (tc) begin
          state_d = ST_SHIFT;
          bit_d   = 3'd0;
          phase_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        // frame is shifted left after each bit so the MSB is always on the pin
        sr_data = frame_q[FRAME_BITS-1];
        sr_clk  = phase_q;
        if (tc) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            if (bit_q < 3'(SW_BITS)) cap_d = {cap_q[SW_BITS-2:0], sr_din};
          end else begin
            phase_d = 1'b0;
            frame_d = frame_q << 1;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'(FRAME_BITS - 1)) state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        sr_latch = 1'b1;
        if (tc) state_d = ST_DONE;
      end
      ST_DONE: begin
        sw_d    = cap_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      io_clk_q <= 1'b1;
      frame_q  <= '0;
      bit_q    <= 3'd0;
      phase_q  <= 1'b0;
      cap_q    <= '0;
      sw_q     <= SW_RESET;
    end else begin
      state_q  <= state_d;
      io_clk_q <= io_clk;
      frame_q  <= frame_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      cap_q    <= cap_d;
      sw_q     <= sw_d;
    end
  end

endmodule

// File: tb/tb_k16_panel_serial.sv
// tb/tb_k16_panel_serial.sv - directed self-checking bench for k16_panel_serial
module tb_k16_panel_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       io_clk, sr_din;
  logic [2:0] io_addr;
  logic [3:0] io_leds, io_switches;
  logic       sr_clk, sr_data, sr_latch, sr_load_n, busy;

  logic       io_clk_b, sr_din_b;
  logic [2:0] io_addr_b;
  logic [3:0] io_leds_b, io_switches_b;
  logic       sr_clk_b, sr_data_b, sr_latch_b, sr_load_n_b, busy_b;

  k16_panel_serial #(.CLK_DIV(4), .FRAME_BITS(8)) dut_a (
    .clk(clk), .reset(reset), .io_clk(io_clk), .io_addr(io_addr), .io_leds(io_leds),
    .io_switches(io_switches), .sr_clk(sr_clk), .sr_data(sr_data), .sr_latch(sr_latch),
    .sr_load_n(sr_load_n), .sr_din(sr_din), .busy(busy)
  );

  k16_panel_serial #(.CLK_DIV(1), .FRAME_BITS(8)) dut_b (
    .clk(clk), .reset(reset), .io_clk(io_clk_b), .io_addr(io_addr_b), .io_leds(io_leds_b),
    .io_switches(io_switches_b), .sr_clk(sr_clk_b), .sr_data(sr_data_b), .sr_latch(sr_latch_b),
    .sr_load_n(sr_load_n_b), .sr_din(sr_din_b), .busy(busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int         rises, latch_cnt, load_cnt, clk_in_latch, busy_cnt;
  logic [7:0] seq;
  logic [3:0] sw_pre, sw_post;
  logic       busy_pre, busy_post, busy_end;
  logic [8:0] snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raises io_clk, then observes cycles 1..ncyc after the start-detect cycle.
  task automatic run_a(input int ncyc, input int reraise_at, input int reset_at, input logic [3:0] pat);
    logic prev_clk;
    rises = 0; latch_cnt = 0; load_cnt = 0; clk_in_latch = 0; busy_cnt = 0;
    seq = 8'h00; prev_clk = 1'b0; snap = '0;
    sr_din = pat[3];
    io_clk = 1'b1;
    tick();
    for (int c = 1; c <= ncyc; c++) begin
      if (sr_clk && !prev_clk) begin
        seq = {seq[6:0], sr_data};
        rises++;
      end
      prev_clk = sr_clk;
      if (sr_latch) latch_cnt++;
      if (sr_latch && sr_clk) clk_in_latch++;
      if (!sr_load_n) load_cnt++;
      if (busy) busy_cnt++;
      if (c == 73) begin sw_pre = io_switches; busy_pre = busy; end
      if (c == 74) begin sw_post = io_switches; busy_post = busy; end
      if (c == reset_at + 1) begin
        snap  = {busy, sr_clk, sr_data, sr_latch, sr_load_n, io_switches};
        reset = 1'b0;
      end
      if (c == reset_at) reset = 1'b1;
      if (reraise_at > 0 && c == 3) io_clk = 1'b0;
      if (c == reraise_at) io_clk = 1'b1;
      sr_din = (rises < 4) ? pat[3 - rises] : 1'b1;
      tick();
    end
    busy_end = busy;
  endtask

  // One 40-cycle io_clk period on the CLK_DIV=1 instance.
  task automatic run_b(input logic [2:0] addr, input logic [3:0] leds, input logic [3:0] pat,
                       input logic [7:0] exp_frame, input logic [3:0] exp_old);
    logic prev_clk;
    rises = 0; busy_cnt = 0; seq = 8'h00; prev_clk = 1'b0;
    io_addr_b = addr; io_leds_b = leds;
    sr_din_b = pat[3];
    io_clk_b = 1'b1;
    tick();
    for (int c = 1; c <= 39; c++) begin
      if (sr_clk_b && !prev_clk) begin
        seq = {seq[6:0], sr_data_b};
        rises++;
      end
      prev_clk = sr_clk_b;
      if (busy_b) busy_cnt++;
      if (c == 19) begin sw_pre = io_switches_b; busy_pre = busy_b; end
      if (c == 20) begin
        sw_post = io_switches_b; busy_post = busy_b;
        io_clk_b = 1'b0;
      end
      sr_din_b = (rises < 4) ? pat[3 - rises] : 1'b1;
      tick();
    end
    chk("b_frame", seq, exp_frame);
    chk("b_pulses", rises, 8);
    chk("b_busy_cycles", busy_cnt, 19);
    chk("b_sw_c19", sw_pre, exp_old);
    chk("b_busy_c19", busy_pre, 1'b1);
    chk("b_sw_c20", sw_post, pat);
    chk("b_busy_c20", busy_post, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    io_clk = 1'b0; io_addr = 3'd0; io_leds = 4'h0; sr_din = 1'b1;
    io_clk_b = 1'b0; io_addr_b = 3'd0; io_leds_b = 4'h0; sr_din_b = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_switches", io_switches, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sr_clk", sr_clk, 1'b0);
    chk("rst_sr_data", sr_data, 1'b0);
    chk("rst_sr_latch", sr_latch, 1'b0);
    chk("rst_sr_load_n", sr_load_n, 1'b1);

    // Transfer with a second io_clk edge arriving while busy
    io_addr = 3'd5; io_leds = 4'hA;
    run_a(90, 20, -1, 4'b1011);
    chk("t1_frame", seq, 8'hA5);
    chk("t1_pulses", rises, 8);
    chk("t1_load_cycles", load_cnt, 4);
    chk("t1_latch_cycles", latch_cnt, 4);
    chk("t1_clk_in_latch", clk_in_latch, 0);
    chk("t1_sw_c73", sw_pre, 4'hF);
    chk("t1_busy_c73", busy_pre, 1'b1);
    chk("t1_sw_c74", sw_post, 4'hB);
    chk("t1_busy_c74", busy_post, 1'b0);
    chk("t1_busy_cycles", busy_cnt, 73);
    chk("t1_busy_end", busy_end, 1'b0);

    // Reset pulse during bit 3 (cycles 29..36), io_clk left high
    io_clk = 1'b0;
    tick();
    run_a(60, 0, 30, 4'b0110);
    chk("rst_mid_idle_levels", snap, 9'h01F);
    chk("rst_mid_latch", latch_cnt, 0);
    chk("rst_mid_busy_cycles", busy_cnt, 30);
    chk("rst_mid_switches", io_switches, 4'hF);
    chk("rst_mid_busy_end", busy_end, 1'b0);

    // io_clk held high through reset release
    io_clk = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      tick();
    end
    chk("hold_high_no_start", busy_cnt, 0);
    io_clk = 1'b0;
    io_addr = 3'd3; io_leds = 4'h9;
    tick();
    run_a(80, 0, -1, 4'b0110);
    chk("hold_high_frame", seq, 8'h93);
    chk("hold_high_sw", sw_post, 4'h6);
    chk("hold_high_busy_c74", busy_post, 1'b0);

    // CLK_DIV=1, back-to-back 40-cycle io_clk periods
    run_b(3'd1, 4'h3, 4'b1011, 8'h31, 4'hF);
    run_b(3'd7, 4'hF, 4'b0110, 8'hF7, 4'hB);
    run_b(3'd2, 4'h8, 4'b1101, 8'h82, 4'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
